alu_16_seq: RTL and testbench
=============================

# alu_16_seq

Multi-cycle sequencer that executes 16-bit ADD/SUB/AND/OR/XOR by driving a single shared `alu_8` instance over successive byte passes: low byte, high byte, then carry/borrow fix-up for arithmetic. It sits between the Z80 decode/execute control and the 8-bit ALU, providing the 16-bit register-pair operations (ADD HL,rr; SBC-style subtraction; 16-bit logic) without a second datapath. Carry/borrow is derived from byte results in this block because `alu_8` exports none.

## Interface

Parameters:
- none (widths fixed: 16-bit operands, 8-bit ALU, 5-bit ALU opcode)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high; one clock; clears all state
- `start`  in  1  request; accepted only when state is IDLE or DONE
- `op`  in  3  0=ADD16, 1=SUB16, 2=AND16, 3=OR16, 4=XOR16, 5-7 invalid
- `a`  in  16  operand A, sampled on accepted start
- `b`  in  16  operand B, sampled on accepted start
- `busy`  out  1  high in LO, HI, FIX
- `done`  out  1  one-cycle pulse in DONE state
- `result`  out  16  registered result; holds until next completion or reset
- `carry`  out  1  carry (ADD) / borrow (SUB); 0 for logic and invalid ops
- `zero`  out  1  registered, `result == 16'h0000`
- `alu_a`  out  8  to `alu_8` a
- `alu_b`  out  8  to `alu_8` b
- `alu_opcode`  out  5  to `alu_8` opcode (0 add, 1 sub, 2 and, 3 or, 4 xor)
- `alu_out`  in  8  from `alu_8` out (combinational)

## Operation

- States: IDLE, LO, HI, FIX, DONE.
- IDLE/DONE + `start`: latch `a`, `b`, `op` → LO. Invalid op → DONE directly, `result`=0, `carry`=0.
- LO: drive (a[7:0], b[7:0], mapped opcode); capture `r_lo = alu_out`. ADD: `c0 = r_lo < a[7:0]`. SUB: `c0 = a[7:0] < b[7:0]`. → HI.
- HI: drive (a[15:8], b[15:8], opcode); capture `t = alu_out`. ADD: `c1 = t < a[15:8]`. SUB: `c1 = a[15:8] < b[15:8]`. Logic: `r_hi = t` → DONE. Arithmetic → FIX.
- FIX: drive (t, {7'b0, c0}, same opcode); `r_hi = alu_out`. ADD: `c2 = c0 & (t == 8'hFF)`. SUB: `c2 = c0 & (t == 8'h00)`. `carry = c1 | c2`. → DONE.
- FIX executes even when c0=0 (fixed latency).
- DONE: `result = {r_hi, r_lo}`, `carry`, `zero` already registered; `done`=1. No `start` → IDLE.
- `alu_a`, `alu_b`, `alu_opcode` are 0 in IDLE and DONE.
- `start` while busy: ignored, no queuing.
- `op`/`a`/`b` changes after acceptance: no effect.

## Timing

- Reset: state IDLE; `busy`=0, `done`=0, `result`=16'h0000, `carry`=0, `zero`=1, ALU drives 0.
- Start sampled at edge k: ADD/SUB `done` high in cycle k+4 (LO k+1, HI k+2, FIX k+3). Logic: `done` at k+3. Invalid: `done` at k+1.
- `result`, `carry`, `zero` update at the edge entering DONE. They are stable while `done`=1 and afterwards.
- Back-to-back: `start` in DONE cycle enters LO next edge. Throughput is 1 op per 4 cycles (arith) or 3 cycles (logic).
- Reset mid-operation: aborts; no `done` pulse; outputs return to reset values next edge.
- ALU path is combinational within one cycle: `alu_out` is sampled at the end of the cycle in which the operands are driven.

## Test plan

- ADD 16'h12FF + 16'h0001 at edge k → `busy` k+1..k+3, `done` at k+4, `result`=16'h1300, `carry`=0, `zero`=0.
- ADD 16'h00FF + 16'hFF01 (carry produced only in FIX) → `result`=16'h0000, `carry`=1, `zero`=1. ADD 16'hFFFF + 16'h0001 → 16'h0000, `carry`=1.
- SUB 16'h1000 − 16'h0001 → 16'h0FFF, `carry`=0. SUB 16'h0000 − 16'h0001 → 16'hFFFF, `carry`=1 (borrow through FIX).
- XOR 16'hFF00 ^ 16'h0FF0 → 16'hF0F0, `carry`=0, `done` at k+3. AND 16'hF0F0 & 16'h0FF0 → 16'h00F0. Invalid op 6 → `done` at k+1, `result`=0.
- `start` held during busy with different operands → ignored, first result unchanged. `start` asserted in DONE cycle → second op (OR 16'h0F00 | 16'h00F0 = 16'h0FF0) completes 3 cycles later.
- `reset` asserted in HI of an ADD → no `done`; next cycle `busy`=0, `result`=0, `zero`=1. A following ADD 16'h0001 + 16'h0001 → 16'h0002.

Source files
------------

// File: rtl/alu_16_seq.sv
// 16-bit ADD/SUB/AND/OR/XOR sequenced over a shared 8-bit ALU.
// Low byte, high byte, then a carry/borrow fix-up pass for arithmetic.
module alu_16_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        carry,
   output logic        zero,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [4:0]  alu_opcode,
   input  logic [7:0]  alu_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_LO, S_HI, S_FIX, S_DONE
   } state_t;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;

   state_t      state_q, state_d;
   logic [2:0]  op_q;
   logic [15:0] a_q, b_q;
   logic [7:0]  r_lo_q, t_q;
   logic        c0_q, c1_q;
   logic [15:0] result_q;
   logic        carry_q, zero_q;

   logic        idle_or_done;
   logic        accept;
   logic        op_valid;
   logic        is_sub;
   logic        is_arith;
   logic        c2;
   logic [15:0] full_res;

   assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
   assign accept       = start && idle_or_done;
   assign op_valid     = (op <= 3'd4);
   assign is_sub       = (op_q == OP_SUB);
   assign is_arith     = (op_q == OP_ADD) || is_sub;
   assign full_res     = {alu_out, r_lo_q};

   // Propagate low-byte carry/borrow through the raw high byte.
   assign c2 = is_sub ? (c0_q && (t_q == 8'h00))
                      : (c0_q && (t_q == 8'hFF));

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (accept)                state_d = op_valid ? S_LO : S_DONE;
            else if (state_q == S_DONE) state_d = S_IDLE;
         end
         S_LO:    state_d = S_HI;
         S_HI:    state_d = is_arith ? S_FIX : S_DONE;
         S_FIX:   state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      alu_a      = 8'h00;
      alu_b      = 8'h00;
      alu_opcode = 5'd0;
      unique case (state_q)
         S_LO: begin
            busy       = 1'b1;
            alu_a      = a_q[7:0];
            alu_b      = b_q[7:0];
            alu_opcode = {2'b00, op_q};
         end
         S_HI: begin
            busy       = 1'b1;
            alu_a      = a_q[15:8];
            alu_b      = b_q[15:8];
            alu_opcode = {2'b00, op_q};
         end
         S_FIX: begin
            busy       = 1'b1;
            alu_a      = t_q;
            alu_b      = {7'b0, c0_q};
            alu_opcode = {2'b00, op_q};
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q     <= 3'd0;
         a_q      <= 16'h0000;
         b_q      <= 16'h0000;
         r_lo_q   <= 8'h00;
         t_q      <= 8'h00;
         c0_q     <= 1'b0;
         c1_q     <= 1'b0;
         result_q <= 16'h0000;
         carry_q  <= 1'b0;
         zero_q   <= 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  op_q <= op;
                  a_q  <= a;
                  b_q  <= b;
                  if (!op_valid) begin
                     result_q <= 16'h0000;
                     carry_q  <= 1'b0;
                     zero_q   <= 1'b1;
                  end
               end
            end
            S_LO: begin
               r_lo_q <= alu_out;
               c0_q   <= is_sub ? (a_q[7:0] < b_q[7:0])
                                : (alu_out < a_q[7:0]);
            end
            S_HI: begin
               t_q  <= alu_out;
               c1_q <= is_sub ? (a_q[15:8] < b_q[15:8])
                              : (alu_out < a_q[15:8]);
               if (!is_arith) begin
                  result_q <= full_res;
                  carry_q  <= 1'b0;
                  zero_q   <= (full_res == 16'h0000);
               end
            end
            S_FIX: begin
               result_q <= full_res;
               carry_q  <= c1_q || c2;
               zero_q   <= (full_res == 16'h0000);
            end
            default: ;
         endcase
      end
   end

   assign result = result_q;
   assign carry  = carry_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_alu_16_seq.sv
// Bench for alu_16_seq with an attached 8-bit ALU model.
// Reference results come from plain 16-bit arithmetic.
module tb_alu_16_seq;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  op;
   logic [15:0] a, b;
   logic        busy, done, carry, zero;
   logic [15:0] result;
   logic [7:0]  alu_a, alu_b, alu_out;
   logic [4:0]  alu_opcode;

   int vecs = 0;
   int errs = 0;

   alu_16_seq dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .carry      (carry),
      .zero       (zero),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_opcode (alu_opcode),
      .alu_out    (alu_out)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_out = 8'h00;
      case (alu_opcode)
         5'd0: alu_out = alu_a + alu_b;
         5'd1: alu_out = alu_a - alu_b;
         5'd2: alu_out = alu_a & alu_b;
         5'd3: alu_out = alu_a | alu_b;
         5'd4: alu_out = alu_a ^ alu_b;
         default: alu_out = 8'h00;
      endcase
   end

   // {carry, result} of a whole 16-bit operation
   function automatic logic [16:0] ref_op(input logic [2:0] o,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
      case (o)
         3'd0: return {1'b0, x} + {1'b0, y};
         3'd1: return {(x < y), x - y};
         3'd2: return {1'b0, x & y};
         3'd3: return {1'b0, x | y};
         3'd4: return {1'b0, x ^ y};
         default: return 17'h0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] o);
      if (o < 3'd2) return 4;
      if (o < 3'd5) return 3;
      return 1;
   endfunction

   // Issue one op from the current cycle; returns cycles until done
   // and a count of busy/ALU-port anomalies seen along the way.
   task automatic do_op(input logic [2:0] o, input logic [15:0] x,
                        input logic [15:0] y, output int lat,
                        output int bad);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
      lat = 1; bad = 0;
      while (!done && lat < 10) begin
         if (busy !== 1'b1) bad++;
         @(posedge clk); #1;
         lat++;
      end
      if (busy !== 1'b0 || {alu_a, alu_b, alu_opcode} !== 21'h0) bad++;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = 3'd0; a = 16'h0; b = 16'h0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      vecs++;
      if ({busy, done, result, carry, zero} !== {2'b00, 16'h0, 2'b01}) begin
         errs++;
         $display("FAIL reset_state got b=%b d=%b r=%h c=%b z=%b need 0 0 0000 0 1",
                  busy, done, result, carry, zero);
      end
      vecs++;
      if ({alu_a, alu_b, alu_opcode} !== 21'h0) begin
         errs++;
         $display("FAIL reset_alu got %h %h %h need 0 0 0",
                  alu_a, alu_b, alu_opcode);
      end
   endtask

   task automatic test_directed;
      logic [2:0]  to[8] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd4, 3'd2, 3'd6};
      logic [15:0] ta[8] = '{16'h12FF, 16'h00FF, 16'hFFFF, 16'h1000,
                             16'h0000, 16'hFF00, 16'hF0F0, 16'h1234};
      logic [15:0] tb[8] = '{16'h0001, 16'hFF01, 16'h0001, 16'h0001,
                             16'h0001, 16'h0FF0, 16'h0FF0, 16'h5678};
      logic [16:0] e;
      int lat, bad;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         do_op(to[i], ta[i], tb[i], lat, bad);
         e = ref_op(to[i], ta[i], tb[i]);
         vecs++;
         if ({carry, result, zero, 4'(lat)} !==
             {e[16], e[15:0], (e[15:0] == 16'h0), 4'(ref_lat(to[i]))}) begin
            errs++;
            $display("FAIL directed_%0d got c=%b r=%h z=%b lat=%0d need c=%b r=%h lat=%0d",
                     i, carry, result, zero, lat, e[16], e[15:0], ref_lat(to[i]));
         end
         vecs++;
         if (bad !== 0) begin
            errs++;
            $display("FAIL directed_busy_%0d got %0d anomalies need 0", i, bad);
         end
      end
   endtask

   task automatic test_random;
      logic [2:0]  o;
      logic [15:0] x, y;
      logic [16:0] e;
      int lat, bad;
      for (int i = 0; i < 60; i++) begin
         o = 3'($urandom_range(0, 7));
         x = 16'($urandom);
         y = 16'($urandom);
         if (i % 5 == 0) x[7:0] = 8'hFF;
         if (i % 7 == 0) y = 16'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
         do_op(o, x, y, lat, bad);
         e = ref_op(o, x, y);
         vecs++;
         if ({carry, result, zero, 4'(lat), 4'(bad)} !==
             {e[16], e[15:0], (e[15:0] == 16'h0), 4'(ref_lat(o)), 4'd0}) begin
            errs++;
            $display("FAIL random_%0d op=%0d %h,%h got c=%b r=%h z=%b lat=%0d bad=%0d need c=%b r=%h",
                     i, o, x, y, carry, result, zero, lat, bad, e[16], e[15:0]);
         end
      end
   endtask

   task automatic test_start_ignored;
      @(posedge clk); #1;
      start = 1'b1; op = 3'd0; a = 16'h12FF; b = 16'h0001;
      @(posedge clk); #1;
      op = 3'd1; a = 16'h5555; b = 16'h1111;
      repeat (3) begin @(posedge clk); #1; end
      start = 1'b0;
      vecs++;
      if ({done, result, carry} !== {1'b1, 16'h1300, 1'b0}) begin
         errs++;
         $display("FAIL held_start got d=%b r=%h c=%b need 1 1300 0",
                  done, result, carry);
      end
      @(posedge clk); #1;
      vecs++;
      if ({done, busy, result} !== {2'b00, 16'h1300}) begin
         errs++;
         $display("FAIL held_start_after got d=%b b=%b r=%h need 0 0 1300",
                  done, busy, result);
      end
   endtask

   task automatic test_back_to_back;
      int lat, bad;
      @(posedge clk); #1;
      do_op(3'd4, 16'hFF00, 16'h0FF0, lat, bad);
      vecs++;
      if ({result, 4'(lat)} !== {16'hF0F0, 4'd3}) begin
         errs++;
         $display("FAIL b2b_first got r=%h lat=%0d need f0f0 3", result, lat);
      end
      do_op(3'd3, 16'h0F00, 16'h00F0, lat, bad);
      vecs++;
      if ({result, carry, 4'(lat), 4'(bad)} !== {16'h0FF0, 1'b0, 4'd3, 4'd0}) begin
         errs++;
         $display("FAIL b2b_second got r=%h c=%b lat=%0d bad=%0d need 0ff0 0 3 0",
                  result, carry, lat, bad);
      end
   endtask

   task automatic test_reset_mid;
      int lat, bad;
      int pulses = 0;
      @(posedge clk); #1;
      start = 1'b1; op = 3'd0; a = 16'h4321; b = 16'h1111;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      vecs++;
      if ({busy, done, result, carry, zero} !== {2'b00, 16'h0, 2'b01}) begin
         errs++;
         $display("FAIL reset_mid got b=%b d=%b r=%h c=%b z=%b need 0 0 0000 0 1",
                  busy, done, result, carry, zero);
      end
      repeat (4) begin
         if (done) pulses++;
         @(posedge clk); #1;
      end
      vecs++;
      if (pulses !== 0) begin
         errs++;
         $display("FAIL reset_mid_nodone got %0d pulses need 0", pulses);
      end
      do_op(3'd0, 16'h0001, 16'h0001, lat, bad);
      vecs++;
      if ({result, carry, zero, 4'(lat)} !== {16'h0002, 2'b00, 4'd4}) begin
         errs++;
         $display("FAIL reset_mid_next got r=%h c=%b z=%b lat=%0d need 0002 0 0 4",
                  result, carry, zero, lat);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_start_ignored;
      test_back_to_back;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
